// File: rtl/debug_mem_sequencer_if.sv
// Load/dump stream and per-channel RAM debug port bundle for debug_mem_sequencer.
// The sequencer takes the slave side; the environment (RAMs, host stream) takes master.
interface debug_mem_sequencer_if #(
    parameter int DW  = 32,
    parameter int NCH = 2
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              In_Valid;
    logic              In_Ready;
    logic              In_Last;
    logic [DW-1:0]     In_Data;
    logic              Out_Valid;
    logic              Out_Ready;
    logic [DW-1:0]     Out_Data;
    logic [CW-1:0]     Out_Chan;
    logic [31:0]       Out_Addr;
    logic [NCH*32-1:0] Dbg_A2;
    logic [NCH*DW-1:0] Dbg_WD2;
    logic [NCH*4-1:0]  Dbg_WE2;
    logic [NCH*DW-1:0] Dbg_RD2;

    modport slave (
        input  In_Valid, In_Last, In_Data, Out_Ready, Dbg_RD2,
        output In_Ready, Out_Valid, Out_Data, Out_Chan, Out_Addr, Dbg_A2, Dbg_WD2, Dbg_WE2
    );
    modport master (
        output In_Valid, In_Last, In_Data, Out_Ready, Dbg_RD2,
        input  In_Ready, Out_Valid, Out_Data, Out_Chan, Out_Addr, Dbg_A2, Dbg_WD2, Dbg_WE2
    );
endinterface

// File: rtl/debug_mem_sequencer.sv
// Debug session sequencer: streams words into per-channel RAMs, pulses the core reset,
// lets the core run until halt/timeout, then streams every RAM word back out.
module debug_mem_sequencer #(
    parameter int WORDS      = 4096,
    parameter int DW         = 32,
    parameter int NCH        = 2,
    parameter int RST_CYCLES = 5,
    parameter int RUN_CYCLES = 200000
) (
    input  logic       CPU_CLK,
    input  logic       CPU_RST_N,
    input  logic       Start,
    input  logic [2:0] Mode,
    input  logic       Core_Halt,
    output logic       Core_Rst,
    output logic       Busy,
    output logic       Done,
    debug_mem_sequencer_if.slave bus
);
    localparam int IW   = $clog2(WORDS);
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MAXC = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RSTP, RUN, DRD, DCAP, DOUT} state_t;

    state_t                  r_state, w_state_nxt;
    logic [2:1]              r_mode;
    logic [IW-1:0]           r_idx, w_idx_nxt;
    logic [CW-1:0]           r_ch, w_ch_nxt;
    logic [TW-1:0]           r_cnt, w_cnt_nxt;
    logic                    r_done, w_done_nxt;
    logic [NCH-1:0][31:0]    r_a2;
    logic [NCH-1:0][DW-1:0]  r_wd;
    logic [NCH-1:0][3:0]     r_we;
    logic [DW-1:0]           r_out_data;
    logic [CW-1:0]           r_out_chan;
    logic [31:0]             r_out_addr;
    logic [NCH-1:0][DW-1:0]  w_rd;
    logic                    w_acc, w_last_word, w_last_ch;
    logic [31:0]             w_addr_cur, w_addr_nxt;

    assign w_acc       = (r_state == LOAD) && bus.In_Valid;
    assign w_last_word = (r_idx == IW'(WORDS - 1));
    assign w_last_ch   = (r_ch == CW'(NCH - 1));
    assign w_addr_cur  = 32'(r_idx) << 2;
    assign w_addr_nxt  = 32'(w_idx_nxt) << 2;
    assign w_rd        = bus.Dbg_RD2;

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_ch_nxt    = r_ch;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: if (Start) begin
                w_cnt_nxt = '0;
                if (Mode[0])      w_state_nxt = LOAD;
                else if (Mode[1]) w_state_nxt = RSTP;
                else if (Mode[2]) w_state_nxt = DRD;
                else              w_done_nxt  = 1'b1;
            end
            LOAD: if (w_acc) begin
                if (bus.In_Last || w_last_word) begin
                    w_idx_nxt = '0;
                    if (w_last_ch) begin
                        w_ch_nxt    = '0;
                        w_state_nxt = r_mode[1] ? RSTP : (r_mode[2] ? DRD : IDLE);
                    end else begin
                        w_ch_nxt = r_ch + 1'b1;
                    end
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            RSTP: if (r_cnt == TW'(RST_CYCLES - 1)) begin
                w_state_nxt = RUN;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            // A halt seen on the expiry cycle takes the same exit, so no priority needed.
            RUN: if (Core_Halt || r_cnt == TW'(RUN_CYCLES - 1)) begin
                w_state_nxt = r_mode[2] ? DRD : IDLE;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
            DRD:  w_state_nxt = DCAP;
            DCAP: w_state_nxt = DOUT;
            DOUT: if (bus.Out_Ready) begin
                w_state_nxt = DRD;
                if (w_last_word) begin
                    w_idx_nxt = '0;
                    if (w_last_ch) begin
                        w_ch_nxt    = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ch_nxt = r_ch + 1'b1;
                    end
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (r_state != IDLE && w_state_nxt == IDLE) w_done_nxt = 1'b1;
    end

    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            r_mode     <= '0;
            r_idx      <= '0;
            r_ch       <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_a2       <= '0;
            r_wd       <= '0;
            r_we       <= '0;
            r_out_data <= '0;
            r_out_chan <= '0;
            r_out_addr <= '0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_ch   <= w_ch_nxt;
            r_cnt  <= w_cnt_nxt;
            r_done <= w_done_nxt;
            if (r_state == IDLE && Start) r_mode <= Mode[2:1];
            r_we <= '0;
            r_a2 <= '0;
            r_wd <= '0;
            // Read address is held through DCAP so a 1-cycle synchronous RAM has it stable.
            if (w_acc) begin
                r_we[r_ch] <= 4'hF;
                r_a2[r_ch] <= w_addr_cur;
                r_wd[r_ch] <= bus.In_Data;
            end else if (w_state_nxt == DRD || w_state_nxt == DCAP) begin
                r_a2[w_ch_nxt] <= w_addr_nxt;
            end
            if (r_state == DCAP) begin
                r_out_data <= w_rd[r_ch];
                r_out_chan <= r_ch;
                r_out_addr <= w_addr_cur;
            end
        end
    end

    assign bus.In_Ready  = (r_state == LOAD);
    assign bus.Out_Valid = (r_state == DOUT);
    assign bus.Out_Data  = r_out_data;
    assign bus.Out_Chan  = r_out_chan;
    assign bus.Out_Addr  = r_out_addr;
    assign bus.Dbg_A2    = r_a2;
    assign bus.Dbg_WD2   = r_wd;
    assign bus.Dbg_WE2   = r_we;
    assign Busy          = (r_state != IDLE);
    assign Core_Rst      = (r_state != RUN);
    assign Done          = r_done;
endmodule

// File: tb/tb_debug_mem_sequencer.sv
// Directed bench for debug_mem_sequencer (WORDS=8, NCH=2, RST_CYCLES=2, RUN_CYCLES=20)
// with a two-channel synchronous RAM model that logs every debug-port write.
module tb_debug_mem_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [2:0] Mode = 3'b000;
    logic       Core_Halt = 1'b0;
    logic       Core_Rst, Busy, Done;
    logic       pre_ld = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [2][8];
    logic [31:0] rd  [2];
    int          q_ch[$];
    int          q_a[$];
    logic [31:0] q_d[$];

    debug_mem_sequencer_if #(.DW(32), .NCH(2)) bus();

    debug_mem_sequencer #(
        .WORDS(8), .DW(32), .NCH(2), .RST_CYCLES(2), .RUN_CYCLES(20)
    ) dut (
        .CPU_CLK(clk), .CPU_RST_N(rst_n), .Start(Start), .Mode(Mode),
        .Core_Halt(Core_Halt), .Core_Rst(Core_Rst), .Busy(Busy), .Done(Done),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_ld) begin
            for (int i = 0; i < 8; i++) begin
                mem[0][i] <= 32'(i);
                mem[1][i] <= 32'h80 + 32'(i);
            end
        end
        for (int k = 0; k < 2; k++) begin
            if (bus.Dbg_WE2[k*4 +: 4] == 4'hF) begin
                mem[k][bus.Dbg_A2[k*32+2 +: 3]] <= bus.Dbg_WD2[k*32 +: 32];
                q_ch.push_back(k);
                q_a.push_back(int'(bus.Dbg_A2[k*32 +: 32]));
                q_d.push_back(bus.Dbg_WD2[k*32 +: 32]);
            end
            rd[k] <= mem[k][bus.Dbg_A2[k*32+2 +: 3]];
        end
    end
    assign bus.Dbg_RD2 = {rd[1], rd[0]};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        bus.In_Valid = 1'b1;
        bus.In_Data  = d;
        bus.In_Last  = last;
        tick();
        bus.In_Valid = 1'b0;
        bus.In_Last  = 1'b0;
    endtask

    task automatic start_session(input logic [2:0] m);
        Start = 1'b1;
        Mode  = m;
        tick();
        Start = 1'b0;
        Mode  = 3'b000;
    endtask

    task automatic check_log(input string tag, input int n, input int ch, input int a,
                             input logic [31:0] d);
        if (n < q_ch.size()) begin
            check({tag, ".ch"}, 64'(q_ch[n]), 64'(ch));
            check({tag, ".addr"}, 64'(q_a[n]), 64'(a));
            check({tag, ".data"}, 64'(q_d[n]), 64'(d));
        end else begin
            check({tag, ".present"}, 64'(q_ch.size()), 64'(n + 1));
        end
    endtask

    initial begin
        int base, rc, runc, nb;
        logic rdy, hs;
        bus.In_Valid  = 1'b0;
        bus.In_Last   = 1'b0;
        bus.In_Data   = '0;
        bus.Out_Ready = 1'b0;

        // reset state
        #12;
        check("rst.busy", 64'(Busy), 64'(0));
        check("rst.done", 64'(Done), 64'(0));
        check("rst.core_rst", 64'(Core_Rst), 64'(1));
        check("rst.in_ready", 64'(bus.In_Ready), 64'(0));
        check("rst.out_valid", 64'(bus.Out_Valid), 64'(0));
        check("rst.we", 64'(bus.Dbg_WE2), 64'(0));
        check("rst.a2", 64'(bus.Dbg_A2), 64'(0));
        rst_n = 1'b1;
        tick();

        // Mode=000: Done one cycle after Start, stays idle
        start_session(3'b000);
        check("m0.done", 64'(Done), 64'(1));
        check("m0.busy", 64'(Busy), 64'(0));
        tick();
        check("m0.done_pulse", 64'(Done), 64'(0));

        // full load of both channels
        base = q_ch.size();
        start_session(3'b001);
        check("ld.busy", 64'(Busy), 64'(1));
        check("ld.in_ready", 64'(bus.In_Ready), 64'(1));
        for (int n = 0; n < 16; n++) beat(32'h100 + 32'(n), 1'b0);
        check("ld.done", 64'(Done), 64'(1));
        check("ld.busy_end", 64'(Busy), 64'(0));
        tick();
        check("ld.count", 64'(q_ch.size() - base), 64'(16));
        for (int n = 0; n < 16; n++)
            check_log("ld", base + n, n / 8, (n % 8) * 4, 32'h100 + 32'(n));

        // early channel end via In_Last; lone In_Last without Valid ignored
        base = q_ch.size();
        start_session(3'b001);
        beat(32'h200, 1'b0);
        beat(32'h201, 1'b0);
        bus.In_Last = 1'b1;
        tick();
        bus.In_Last = 1'b0;
        beat(32'h202, 1'b1);
        beat(32'h203, 1'b0);
        beat(32'h204, 1'b1);
        check("last.done", 64'(Done), 64'(1));
        tick();
        check("last.count", 64'(q_ch.size() - base), 64'(5));
        check_log("last0", base + 0, 0, 0, 32'h200);
        check_log("last1", base + 1, 0, 4, 32'h201);
        check_log("last2", base + 2, 0, 8, 32'h202);
        check_log("last3", base + 3, 1, 0, 32'h203);
        check_log("last4", base + 4, 1, 4, 32'h204);

        // run to timeout, with a Start pulse mid-run that must be ignored
        start_session(3'b010);
        rc = 0;
        runc = 0;
        for (int c = 0; c < 200 && !Done; c++) begin
            if (Busy && Core_Rst) rc++;
            if (!Core_Rst) runc++;
            if (!Core_Rst && runc == 3) begin
                Start = 1'b1;
                Mode  = 3'b001;
            end else begin
                Start = 1'b0;
                Mode  = 3'b000;
            end
            tick();
        end
        check("run.rst_cycles", 64'(rc), 64'(2));
        check("run.run_cycles", 64'(runc), 64'(20));
        check("run.done", 64'(Done), 64'(1));
        check("run.in_ready", 64'(bus.In_Ready), 64'(0));
        tick();
        check("run.done_pulse", 64'(Done), 64'(0));

        // run ended by halt on RUN cycle 5
        start_session(3'b010);
        rc = 0;
        runc = 0;
        for (int c = 0; c < 200 && !Done; c++) begin
            if (Busy && Core_Rst) rc++;
            if (!Core_Rst) runc++;
            Core_Halt = (!Core_Rst && runc == 5);
            tick();
        end
        Core_Halt = 1'b0;
        check("halt.rst_cycles", 64'(rc), 64'(2));
        check("halt.run_cycles", 64'(runc), 64'(5));
        check("halt.done", 64'(Done), 64'(1));
        tick();

        // dump with toggling Out_Ready
        pre_ld = 1'b1;
        tick();
        pre_ld = 1'b0;
        start_session(3'b100);
        nb  = 0;
        rdy = 1'b0;
        for (int c = 0; c < 400 && !Done; c++) begin
            if (bus.Out_Valid) begin
                check("dump.chan", 64'(bus.Out_Chan), 64'(nb / 8));
                check("dump.addr", 64'(bus.Out_Addr), 64'((nb % 8) * 4));
                check("dump.data", 64'(bus.Out_Data),
                      (nb / 8 == 1) ? 64'(32'h80 + 32'(nb % 8)) : 64'(nb % 8));
                check("dump.core_rst", 64'(Core_Rst), 64'(1));
            end
            bus.Out_Ready = rdy;
            hs = bus.Out_Valid && rdy;
            tick();
            if (hs) nb++;
            rdy = !rdy;
        end
        bus.Out_Ready = 1'b0;
        check("dump.beats", 64'(nb), 64'(16));
        check("dump.done", 64'(Done), 64'(1));
        check("dump.out_valid_idle", 64'(bus.Out_Valid), 64'(0));
        tick();

        // asynchronous reset in the middle of a load
        start_session(3'b001);
        for (int n = 0; n < 6; n++) beat(32'h900 + 32'(n), 1'b0);
        check("mid.we_before", 64'(bus.Dbg_WE2), 64'(4'hF));
        rst_n = 1'b0;
        #1;
        check("mid.we", 64'(bus.Dbg_WE2), 64'(0));
        check("mid.a2", 64'(bus.Dbg_A2), 64'(0));
        check("mid.busy", 64'(Busy), 64'(0));
        check("mid.core_rst", 64'(Core_Rst), 64'(1));
        check("mid.in_ready", 64'(bus.In_Ready), 64'(0));
        check("mid.out_data", 64'(bus.Out_Data), 64'(0));
        #1;
        rst_n = 1'b1;
        tick();
        base = q_ch.size();
        start_session(3'b001);
        check("post.busy", 64'(Busy), 64'(1));
        beat(32'h300, 1'b1);
        beat(32'h301, 1'b1);
        check("post.done", 64'(Done), 64'(1));
        tick();
        check("post.count", 64'(q_ch.size() - base), 64'(2));
        check_log("post0", base + 0, 0, 0, 32'h300);
        check_log("post1", base + 1, 1, 0, 32'h301);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
